// File: rtl/voice_allocator_pkg.sv
// Shared types for the polyphonic voice allocator.
// FSM state encoding used by the allocator and the voice-bank top level.
package voice_allocator_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PICK_RETRIG = 2'd0,
        PICK_FREE   = 2'd1,
        PICK_STEAL  = 2'd2
    } pick_t;

endpackage

// File: rtl/voice_allocator_select.sv
// Combinational voice picker: note match, first free voice, oldest voice.
// Lowest index wins every tie so the choice is deterministic.
module voice_select #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7,
    parameter int SEQ_BITS   = 8,
    localparam int IDX_BITS  = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]                gates,
    input  logic [NUM_VOICES-1:0][NOTE_BITS-1:0] notes,
    input  logic [NUM_VOICES-1:0][SEQ_BITS-1:0]  stamps,
    input  logic [SEQ_BITS-1:0]                  seq,
    input  logic [NOTE_BITS-1:0]                 ev_note,
    output logic [IDX_BITS-1:0]                  match_idx,
    output logic                                 match_hit,
    output logic [IDX_BITS-1:0]                  free_idx,
    output logic                                 free_hit,
    output logic [IDX_BITS-1:0]                  oldest_idx
);

    logic [SEQ_BITS-1:0] best_age;
    logic [SEQ_BITS-1:0] age;

    // Scan downwards so the lowest matching / free index is the last written
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gates[i] && notes[i] == ev_note) begin
                match_hit = 1'b1;
                match_idx = IDX_BITS'(i);
            end
            if (!gates[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_BITS'(i);
            end
        end
    end

    // Largest modular age wins; strict compare keeps the lowest index on ties
    always_comb begin
        best_age   = seq - stamps[0];
        age        = '0;
        oldest_idx = '0;
        for (int i = 1; i < NUM_VOICES; i++) begin
            age = seq - stamps[i];
            if (age > best_age) begin
                best_age   = age;
                oldest_idx = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: maps note events onto voices,
// retriggers or steals with a gate-low hold to force an envelope edge.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES    = 4,
    parameter int FREQ_BITS     = 16,
    parameter int NOTE_BITS     = 7,
    parameter int SEQ_BITS      = 8,
    parameter int RETRIG_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_note_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic [FREQ_BITS-1:0]            ev_freq,
    input  logic                            panic,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
    output logic                            steal_pulse
);

    localparam int IDX_BITS = $clog2(NUM_VOICES);
    localparam int CNT_BITS = $clog2(RETRIG_CYCLES + 1);

    state_t                               state, state_nx;
    logic [NUM_VOICES-1:0]                gate;
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] notes;
    logic [NUM_VOICES-1:0][SEQ_BITS-1:0]  stamps;
    logic [NUM_VOICES-1:0][FREQ_BITS-1:0] freqs;
    logic [SEQ_BITS-1:0]                  seq;
    logic [CNT_BITS-1:0]                  cnt;
    logic [IDX_BITS-1:0]                  tgt;

    logic [IDX_BITS-1:0] match_idx, free_idx, oldest_idx, sel;
    logic                match_hit, free_hit;
    logic                acc_on, acc_off, hold_done;
    pick_t               pick;

    voice_select #(
        .NUM_VOICES(NUM_VOICES),
        .NOTE_BITS (NOTE_BITS),
        .SEQ_BITS  (SEQ_BITS)
    ) u_sel (
        .gates     (gate),
        .notes     (notes),
        .stamps    (stamps),
        .seq       (seq),
        .ev_note   (ev_note),
        .match_idx (match_idx),
        .match_hit (match_hit),
        .free_idx  (free_idx),
        .free_hit  (free_hit),
        .oldest_idx(oldest_idx)
    );

    assign ev_ready   = (state == ST_IDLE) & ~panic & rst;
    assign voice_gate = gate;
    assign voice_freq = freqs;

    // Next state, accept strobes and target choice (retrigger > free > steal)
    always_comb begin
        state_nx  = state;
        acc_on    = 1'b0;
        acc_off   = 1'b0;
        hold_done = 1'b0;
        pick      = match_hit ? PICK_RETRIG :
                    free_hit  ? PICK_FREE   : PICK_STEAL;
        sel       = match_hit ? match_idx :
                    free_hit  ? free_idx  : oldest_idx;
        unique case (state)
            ST_IDLE: begin
                if (ev_valid && ev_ready) begin
                    acc_on  = ev_note_on;
                    acc_off = ~ev_note_on;
                    if (ev_note_on && pick != PICK_FREE)
                        state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (panic) begin
                    state_nx = ST_IDLE;
                end else if (cnt == CNT_BITS'(1)) begin
                    hold_done = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Voice table, age stamps, hold counter and steal strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate        <= '0;
            notes       <= '0;
            stamps      <= '0;
            freqs       <= '0;
            seq         <= '0;
            cnt         <= '0;
            tgt         <= '0;
            steal_pulse <= 1'b0;
        end else begin
            steal_pulse <= 1'b0;
            if (state == ST_HOLD && !panic)
                cnt <= cnt - 1'b1;
            if (panic) begin
                gate <= '0;
            end else if (hold_done) begin
                gate[tgt] <= 1'b1;
            end else if (acc_off) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    if (gate[i] && notes[i] == ev_note)
                        gate[i] <= 1'b0;
            end else if (acc_on) begin
                freqs[sel]  <= ev_freq;
                notes[sel]  <= ev_note;
                stamps[sel] <= seq;
                seq         <= seq + 1'b1;
                gate[sel]   <= (pick == PICK_FREE);
                tgt         <= sel;
                cnt         <= CNT_BITS'(RETRIG_CYCLES);
                steal_pulse <= (pick == PICK_STEAL);
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vectors with literal
// expectations plus a per-cycle comparison against a note-table model.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int FB = 16;
    localparam int NB = 7;
    localparam int R  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_note_on = 1'b0;
    logic [NB-1:0] ev_note = '0;
    logic [FB-1:0] ev_freq = '0;
    logic          panic = 1'b0;
    logic [NV-1:0] voice_gate;
    logic [NV*FB-1:0] voice_freq;
    logic          steal_pulse;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_VOICES(NV), .FREQ_BITS(FB), .NOTE_BITS(NB),
        .SEQ_BITS(8), .RETRIG_CYCLES(R)
    ) dut (
        .clk(clk), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_note_on(ev_note_on), .ev_note(ev_note), .ev_freq(ev_freq),
        .panic(panic),
        .voice_gate(voice_gate), .voice_freq(voice_freq),
        .steal_pulse(steal_pulse)
    );

    // Model: note table with absolute allocation order
    bit            m_gate [NV];
    int            m_note [NV];
    logic [FB-1:0] m_freq [NV];
    int            m_last [NV];
    int            m_alloc, m_hold, m_tgt;
    bit            m_steal;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_freq[i] = '0; m_last[i] = 0;
        end
        m_alloc = 0; m_hold = 0; m_tgt = 0; m_steal = 0;
    endtask

    task automatic model_step();
        int t;
        m_steal = 0;
        if (panic) begin
            for (int i = 0; i < NV; i++) m_gate[i] = 0;
            m_hold = 0;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_gate[m_tgt] = 1;
        end else if (ev_valid) begin
            if (!ev_note_on) begin
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] && m_note[i] == int'(ev_note)) m_gate[i] = 0;
            end else begin
                t = -1;
                for (int i = 0; i < NV; i++)
                    if (t < 0 && m_gate[i] && m_note[i] == int'(ev_note)) t = i;
                if (t >= 0) begin
                    m_gate[t] = 0; m_hold = R;
                end else begin
                    for (int i = 0; i < NV; i++)
                        if (t < 0 && !m_gate[i]) t = i;
                    if (t >= 0) begin
                        m_gate[t] = 1;
                    end else begin
                        t = 0;
                        for (int i = 1; i < NV; i++)
                            if (m_last[i] < m_last[t]) t = i;
                        m_gate[t] = 0; m_hold = R; m_steal = 1;
                    end
                    m_note[t] = int'(ev_note);
                end
                m_freq[t] = ev_freq;
                m_last[t] = m_alloc;
                m_alloc++;
                m_tgt = t;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        logic [NV-1:0]    eg;
        logic [NV*FB-1:0] ef;
        if (cmp_en) begin
            for (int i = 0; i < NV; i++) begin
                eg[i] = m_gate[i];
                ef[i*FB +: FB] = m_freq[i];
            end
            chk("model_gate", 64'(voice_gate), 64'(eg));
            chk("model_freq", 64'(voice_freq), 64'(ef));
            chk("model_steal", 64'(steal_pulse), 64'(m_steal));
            chk("model_ready", 64'(ev_ready),
                64'(rst && m_hold == 0 && !panic));
        end
    end

    function automatic logic [FB-1:0] fs(int i);
        return voice_freq[i*FB +: FB];
    endfunction

    // Present one event, wait (bounded) for ready, return 1ns after accept
    task automatic send(bit on, int note, logic [FB-1:0] f);
        int n;
        n = 0;
        ev_valid = 1'b1; ev_note_on = on;
        ev_note = NB'(note); ev_freq = f;
        while (!ev_ready && n <= 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n > 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: got ready=0 want ready=1 note %0d", note);
        end else begin
            @(posedge clk); #1;
        end
        ev_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_gate", 64'(voice_gate), 64'h0);
        chk("rst_freq", 64'(voice_freq), 64'h0);
        chk("rst_steal", 64'(steal_pulse), 64'h0);
        chk("rst_ready", 64'(ev_ready), 64'h0);
        rst = 1'b1;
        step();

        // 1: three notes fill voices 0..2
        send(1, 60, 16'h1000);
        chk("t1_gate0", 64'(voice_gate), 64'b0001);
        send(1, 64, 16'h2000);
        send(1, 67, 16'h3000);
        chk("t1_gate", 64'(voice_gate), 64'b0111);
        chk("t1_f0", 64'(fs(0)), 64'h1000);
        chk("t1_f1", 64'(fs(1)), 64'h2000);
        chk("t1_f2", 64'(fs(2)), 64'h3000);

        // 2: note-off present and absent
        send(0, 64, 16'h0);
        chk("t2_off", 64'(voice_gate), 64'b0101);
        send(0, 99, 16'h0);
        chk("t2_absent", 64'(voice_gate), 64'b0101);
        chk("t2_ready", 64'(ev_ready), 64'h1);

        // 3: fill all four, then steal the oldest (voice 0)
        send(0, 60, 16'h0);
        send(0, 67, 16'h0);
        send(1, 60, 16'h1100);
        send(1, 62, 16'h2200);
        send(1, 64, 16'h3300);
        send(1, 65, 16'h4400);
        chk("t3_full", 64'(voice_gate), 64'b1111);
        send(1, 67, 16'h4444);
        chk("t3_steal", 64'(steal_pulse), 64'h1);
        chk("t3_gate", 64'(voice_gate), 64'b1110);
        chk("t3_rdy", 64'(ev_ready), 64'h0);
        for (int k = 1; k < R; k++) begin
            step();
            chk("t3_low", 64'(voice_gate), 64'b1110);
            chk("t3_hold_rdy", 64'(ev_ready), 64'h0);
        end
        chk("t3_strobe", 64'(steal_pulse), 64'h0);
        step();
        chk("t3_up", 64'(voice_gate), 64'b1111);
        chk("t3_f0", 64'(fs(0)), 64'h4444);
        chk("t3_rdy1", 64'(ev_ready), 64'h1);

        // 4: retrigger note 62 on voice 1
        send(1, 62, 16'h5555);
        chk("t4_steal", 64'(steal_pulse), 64'h0);
        for (int k = 0; k < R; k++) begin
            chk("t4_low", 64'(voice_gate), 64'b1101);
            step();
        end
        chk("t4_up", 64'(voice_gate), 64'b1111);
        chk("t4_f1", 64'(fs(1)), 64'h5555);

        // 5: panic during a steal hold (voice 2 is oldest)
        send(1, 70, 16'h6666);
        chk("t5_gate", 64'(voice_gate), 64'b1011);
        panic = 1'b1;
        ev_valid = 1'b1; ev_note_on = 1'b1;
        ev_note = NB'(72); ev_freq = 16'h7777;
        step();
        chk("t5_clear", 64'(voice_gate), 64'b0000);
        chk("t5_rdy", 64'(ev_ready), 64'h0);
        step();
        chk("t5_blocked", 64'(fs(0)), 64'h4444);
        panic = 1'b0;
        #1;
        chk("t5_idle", 64'(ev_ready), 64'h1);
        step();
        ev_valid = 1'b0;
        chk("t5_acc", 64'(voice_gate), 64'b0001);
        chk("t5_f0", 64'(fs(0)), 64'h7777);
        chk("t5_f2", 64'(fs(2)), 64'h6666);

        // 6: long run of note-ons, sequence counter wraps
        for (int i = 0; i < 300; i++)
            send(1, int'($urandom_range(30, 100)), FB'(i + 256));
        send(1, 127, 16'hBEEF);
        chk("t6_steal", 64'(steal_pulse), 64'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_gate", 64'(voice_gate), 64'h0);
        chk("t6_rst_freq", 64'(voice_freq), 64'h0);
        chk("t6_rst_steal", 64'(steal_pulse), 64'h0);
        chk("t6_rst_rdy", 64'(ev_ready), 64'h0);
        @(posedge clk); #1;
        for (int k = 0; k < R + 2; k++) step();
        chk("t6_no_pulse", 64'(voice_gate), 64'h0);
        rst = 1'b1;
        step();
        send(1, 50, 16'hABCD);
        chk("t6_recover", 64'(voice_gate), 64'b0001);
        chk("t6_rf0", 64'(fs(0)), 64'hABCD);
        step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
